// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver with double-buffered value capture.
// Optional LEADING_ZERO_BLANK_EN: darkens leading zero digits (digit 0 always shown).
module seven_segment_scan_driver #(
    parameter int NUM_DIGITS       = 2,
    parameter int REFRESH_COUNT    = 50000,
    parameter int BLANK_CYCLES     = 500,
    parameter int ANODE_ACTIVE_LOW = 1,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] values,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digit_enable,
    output logic [6:0]              segments,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic                    frame_start,
    output logic [IDX_W-1:0]        digit_index
);

    localparam int CNT_W = $clog2(REFRESH_COUNT);
    localparam int W     = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0]      LAST_CNT   = CNT_W'(REFRESH_COUNT - 1);
    localparam logic [CNT_W-1:0]      BLANK_C    = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODES_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW != 0}};

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [W-1:0]          active_q, active_d;
    logic [W-1:0]          pending_q, pending_d;
    logic                  pend_valid_q, pend_valid_d;
    logic                  commit_q;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic                  frame_q, frame_d;
    logic [IDX_W-1:0]      dig_q;

    logic                  term;
    logic                  commit;
    logic [NUM_DIGITS-1:0] suppress;
    logic [NUM_DIGITS-1:0] onehot;
    logic [3:0]            sel_nib;
    logic                  sel_on;
    logic                  show;
`ifdef LEADING_ZERO_BLANK_EN
    logic                  lead;
`endif

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign term   = (cnt_q == LAST_CNT);
    assign commit = term && (idx_q == LAST_IDX);

    always_comb begin
        cnt_d        = term ? '0 : cnt_q + 1'b1;
        idx_d        = idx_q;
        active_d     = active_q;
        pending_d    = pending_q;
        pend_valid_d = pend_valid_q;
        suppress     = '0;
        onehot       = '0;
        sel_nib      = 4'h0;
        sel_on       = 1'b0;

        if (term) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end

        // The old pending word commits first; a coincident load refills pending.
        if (commit) begin
            if (pend_valid_q) begin
                active_d = pending_q;
            end
            pend_valid_d = 1'b0;
        end
        if (load) begin
            pending_d    = values;
            pend_valid_d = 1'b1;
        end

`ifdef LEADING_ZERO_BLANK_EN
        lead = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            lead        = lead & (active_q[4*k +: 4] == 4'h0);
            suppress[k] = lead;
        end
`endif

        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                onehot[k] = 1'b1;
                sel_nib   = active_q[4*k +: 4];
                sel_on    = digit_enable[k] & ~suppress[k];
            end
        end

        show    = sel_on && (cnt_q >= BLANK_C);
        seg_d   = show ? decode(sel_nib) : 7'b1111111;
        anode_d = (show ? onehot : '0) ^ ANODES_OFF;
        // commit_q marks the first cycle of a new frame in the counter domain.
        frame_d = commit_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            active_q     <= '0;
            pending_q    <= '0;
            pend_valid_q <= 1'b0;
            commit_q     <= 1'b0;
            seg_q        <= 7'b1111111;
            anode_q      <= ANODES_OFF;
            frame_q      <= 1'b0;
            dig_q        <= '0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            pend_valid_q <= pend_valid_d;
            commit_q     <= commit;
            seg_q        <= seg_d;
            anode_q      <= anode_d;
            frame_q      <= frame_d;
            dig_q        <= idx_q;
        end
    end

    assign segments    = seg_q;
    assign anodes      = anode_q;
    assign frame_start = frame_q;
    assign digit_index = dig_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Bench for seven_segment_scan_driver: position-based pin model with an expected-value queue.
// Build with LEADING_ZERO_BLANK_EN defined to cover leading-zero suppression.
module tb_seven_segment_scan_driver;

    localparam int N  = 4;
    localparam int RC = 4;
    localparam int BL = 1;
    localparam int FRAME = N * RC;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] values;
    logic [3:0]  digit_enable;
    logic [6:0]  segments;
    logic [3:0]  anodes;
    logic        frame_start;
    logic [1:0]  digit_index;

    seven_segment_scan_driver #(
        .NUM_DIGITS(N),
        .REFRESH_COUNT(RC),
        .BLANK_CYCLES(BL),
        .ANODE_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .values(values),
        .load(load),
        .digit_enable(digit_enable),
        .segments(segments),
        .anodes(anodes),
        .frame_start(frame_start),
        .digit_index(digit_index)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          m_n;
    logic [15:0] m_active;
    logic [15:0] m_pending;
    logic        m_valid;
    logic [13:0] exp_q[$];
    logic [6:0]  seg_tab[16];
    int          lit_cnt[4];
    logic [6:0]  seg_seen[4];
    int          fs_wait;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic sup(input logic [15:0] w, input int k);
        return LZ && (k != 0) && ((w >> (4 * k)) == 16'h0);
    endfunction

    // One clock: predict pins from the frame position reached so far, then compare.
    task automatic step();
        logic [13:0] e;
        int p, cnt, idx;
        logic lit;
        p = m_n % FRAME;
        if (reset) begin
            e = {1'b0, 2'd0, 4'hF, 7'h7F};
        end else begin
            cnt = p % RC;
            idx = p / RC;
            lit = (cnt >= BL) && digit_enable[idx] && !sup(m_active, idx);
            e[13]    = (p == 0) && (m_n > 0);
            e[12:11] = idx[1:0];
            e[10:7]  = lit ? ~(4'b0001 << idx) : 4'hF;
            e[6:0]   = lit ? seg_tab[m_active[4*idx +: 4]] : 7'h7F;
        end
        exp_q.push_back(e);
        if (reset) begin
            m_n = 0;
            m_active = 16'h0;
            m_pending = 16'h0;
            m_valid = 1'b0;
        end else begin
            if (p == FRAME - 1) begin
                if (m_valid) m_active = m_pending;
                m_valid = 1'b0;
            end
            if (load) begin
                m_pending = values;
                m_valid = 1'b1;
            end
            m_n++;
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("pins", {18'h0, frame_start, digit_index, anodes, segments}, {18'h0, e});
    endtask

    task automatic wait_first_fs(output int n);
        n = 0;
        step();
        while (!frame_start && n < 40) begin
            step();
            n++;
        end
    endtask

    // Records one full frame of pins starting at a frame_start; optional loads at offsets la/lb.
    task automatic capture_frame(input int la, input logic [15:0] va, input int lb, input logic [15:0] vb);
        for (int k = 0; k < N; k++) begin
            lit_cnt[k] = 0;
            seg_seen[k] = 7'h7F;
        end
        for (int i = 0; i < FRAME; i++) begin
            for (int k = 0; k < N; k++) begin
                if (anodes == ~(4'b0001 << k)) begin
                    lit_cnt[k]++;
                    seg_seen[k] = segments;
                end
            end
            load = 1'b0;
            if (i == la) begin
                values = va;
                load = 1'b1;
            end else if (i == lb) begin
                values = vb;
                load = 1'b1;
            end
            step();
        end
        load = 1'b0;
        check("frame_len", {31'h0, frame_start}, 32'h1);
    endtask

    task automatic check_frame(input string tag, input logic [15:0] w, input logic [3:0] en);
        logic on;
        for (int k = 0; k < N; k++) begin
            on = en[k] && !sup(w, k);
            check($sformatf("%s_lit%0d", tag, k), lit_cnt[k], on ? 3 : 0);
            if (on) check($sformatf("%s_seg%0d", tag, k), {25'h0, seg_seen[k]}, {25'h0, seg_tab[w[4*k +: 4]]});
        end
    endtask

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        m_n = 0;
        m_active = 16'h0;
        m_pending = 16'h0;
        m_valid = 1'b0;
        reset = 1'b1;
        load = 1'b0;
        values = 16'h0;
        digit_enable = 4'hF;

        step();
        step();
        check("reset_seg", {25'h0, segments}, 32'h7F);
        check("reset_an", {28'h0, anodes}, 32'hF);
        check("reset_fs", {31'h0, frame_start}, 32'h0);
        check("reset_idx", {30'h0, digit_index}, 32'h0);
        reset = 1'b0;
        wait_first_fs(fs_wait);
        check("first_fs", fs_wait, 16);

        capture_frame(2, 16'hF81A, -1, 16'h0);
        check_frame("s1_zero", 16'h0000, 4'hF);
        capture_frame(-1, 16'h0, -1, 16'h0);
        check_frame("s2", 16'hF81A, 4'hF);
        check("s2_d0", {25'h0, seg_seen[0]}, {25'h0, 7'b0001000});
        check("s2_d1", {25'h0, seg_seen[1]}, {25'h0, 7'b1111001});
        check("s2_d2", {25'h0, seg_seen[2]}, {25'h0, 7'b0000000});
        check("s2_d3", {25'h0, seg_seen[3]}, {25'h0, 7'b0001110});

        capture_frame(5, 16'h1234, -1, 16'h0);
        check_frame("s3_old", 16'hF81A, 4'hF);
        capture_frame(-1, 16'h0, -1, 16'h0);
        check_frame("s3_new", 16'h1234, 4'hF);

        capture_frame(2, 16'h5555, 14, 16'hAAAA);
        check_frame("s4_cur", 16'h1234, 4'hF);
        capture_frame(-1, 16'h0, -1, 16'h0);
        check_frame("s4_5555", 16'h5555, 4'hF);
        capture_frame(-1, 16'h0, -1, 16'h0);
        check_frame("s4_AAAA", 16'hAAAA, 4'hF);

        capture_frame(2, 16'h8888, -1, 16'h0);
        check_frame("s5_prev", 16'hAAAA, 4'hF);
        digit_enable = 4'b0101;
        capture_frame(-1, 16'h0, -1, 16'h0);
        check_frame("s5_en", 16'h8888, 4'b0101);
        check("s5_d1_dark", lit_cnt[1], 0);
        check("s5_d3_dark", lit_cnt[3], 0);
        digit_enable = 4'hF;

        capture_frame(2, 16'h0070, -1, 16'h0);
        check_frame("s6_prev", 16'h8888, 4'hF);
        capture_frame(2, 16'h0000, -1, 16'h0);
        check_frame("s6_0070", 16'h0070, 4'hF);
        check("s6_d1", {25'h0, seg_seen[1]}, {25'h0, 7'b1111000});
        check("s6_d0", {25'h0, seg_seen[0]}, {25'h0, 7'b1000000});
        check("s6_d3_lit", lit_cnt[3], LZ ? 0 : 3);
        check("s6_d2_lit", lit_cnt[2], LZ ? 0 : 3);
        capture_frame(-1, 16'h0, -1, 16'h0);
        check_frame("s6_0000", 16'h0000, 4'hF);
        check("s6z_d1_lit", lit_cnt[1], LZ ? 0 : 3);
        check("s6z_d0_lit", lit_cnt[0], 3);

        for (int c = 0; c < 150; c++) begin
            digit_enable = 4'($urandom_range(0, 15));
            load = ($urandom_range(0, 9) == 0);
            values = 16'($urandom());
            step();
        end
        load = 1'b0;
        digit_enable = 4'hF;
        step();
        step();
        step();

        reset = 1'b1;
        load = 1'b1;
        values = 16'hFFFF;
        step();
        check("midreset_an", {28'h0, anodes}, 32'hF);
        step();
        reset = 1'b0;
        load = 1'b0;
        wait_first_fs(fs_wait);
        check("fs_after_reset", fs_wait, 16);
        capture_frame(-1, 16'h0, -1, 16'h0);
        check_frame("post_reset", 16'h0000, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
